// File: rtl/final_logic_param.sv
// VC-to-destination crossbar stage: arbitrates NUM_VC FWFT input FIFOs into NUM_DEST FWFT destination FIFOs.
// Latency: 1 cycle from grant to destination head; pop_vc is combinational and stalls on almost-full or init.
module final_logic_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 init,
  input  logic [NUM_VC*DATA_WIDTH-1:0]         data_out_vc,
  input  logic [NUM_VC-1:0]                    empty_fifo_vc,
  input  logic [NUM_DEST-1:0]                  dest_pop,
  input  logic [NUM_DEST*(ADDR_WIDTH+1)-1:0]   umbral,
  output logic [NUM_VC-1:0]                    pop_vc,
  output logic [NUM_DEST*DATA_WIDTH-1:0]       data_out_dest,
  output logic [NUM_DEST-1:0]                  empty_fifo_dest,
  output logic [NUM_DEST-1:0]                  almost_full_dest,
  output logic [NUM_DEST-1:0]                  error_dest
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam int DEST_W = (NUM_DEST > 2) ? $clog2(NUM_DEST) : 1;
  localparam int VC_W   = $clog2(NUM_VC);

  logic [DATA_WIDTH-1:0] r_mem     [NUM_DEST][DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr  [NUM_DEST];
  logic [ADDR_WIDTH-1:0] r_rd_ptr  [NUM_DEST];
  logic [CW-1:0]         r_count   [NUM_DEST];
  logic [CW-1:0]         r_thr     [NUM_DEST];
  logic [NUM_DEST-1:0]   r_err;
  logic [VC_W-1:0]       r_rr_ptr;

  logic [DEST_W-1:0]     w_vc_dest [NUM_VC];
  logic [CW-1:0]         w_thr_eff [NUM_DEST];
  logic [NUM_VC-1:0]     w_elig;
  logic                  w_gnt_vld;
  logic [VC_W-1:0]       w_gnt_idx;
  logic [DATA_WIDTH-1:0] w_gnt_word;
  logic [DEST_W-1:0]     w_gnt_dest;
  logic [NUM_DEST-1:0]   w_push;
  logic [NUM_DEST-1:0]   w_wr_ok;
  logic [NUM_DEST-1:0]   w_pop;

  // Out-of-range destination fields fold onto the last destination.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_vc_dest[v] = data_out_vc[v*DATA_WIDTH + DATA_WIDTH-1 -: DEST_W];
      if (int'(w_vc_dest[v]) >= NUM_DEST) w_vc_dest[v] = DEST_W'(NUM_DEST-1);
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_DEST; d++) begin
      w_thr_eff[d] = (r_thr[d] == '0 || r_thr[d] > CW'(DEPTH)) ? CW'(DEPTH) : r_thr[d];
      almost_full_dest[d] = (r_count[d] >= w_thr_eff[d]) || (r_count[d] == CW'(DEPTH));
      empty_fifo_dest[d]  = (r_count[d] == '0);
      data_out_dest[d*DATA_WIDTH +: DATA_WIDTH] =
        empty_fifo_dest[d] ? '0 : r_mem[d][r_rd_ptr[d]];
    end
    error_dest = r_err;
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++)
      w_elig[v] = !empty_fifo_vc[v] && !almost_full_dest[w_vc_dest[v]] && !init && !reset;
  end

  // Loops run downward so the last hit is the lowest index / nearest offset.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (ARB_MODE == 0) begin
      for (int v = NUM_VC-1; v >= 0; v--)
        if (w_elig[v]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = VC_W'(v);
        end
    end else begin
      for (int k = NUM_VC-1; k >= 0; k--)
        if (w_elig[(int'(r_rr_ptr) + k) % NUM_VC]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = VC_W'((int'(r_rr_ptr) + k) % NUM_VC);
        end
    end
  end

  always_comb begin
    w_gnt_word = '0;
    w_gnt_dest = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop_vc[v] = w_gnt_vld && (w_gnt_idx == VC_W'(v));
      if (w_gnt_idx == VC_W'(v)) begin
        w_gnt_word = data_out_vc[v*DATA_WIDTH +: DATA_WIDTH];
        w_gnt_dest = w_vc_dest[v];
      end
    end
    for (int d = 0; d < NUM_DEST; d++) begin
      w_push[d]  = w_gnt_vld && (w_gnt_dest == DEST_W'(d));
      w_wr_ok[d] = w_push[d] && (r_count[d] != CW'(DEPTH));
      w_pop[d]   = dest_pop[d] && (r_count[d] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err    <= '0;
      r_rr_ptr <= '0;
      for (int d = 0; d < NUM_DEST; d++) begin
        r_wr_ptr[d] <= '0;
        r_rd_ptr[d] <= '0;
        r_count[d]  <= '0;
        r_thr[d]    <= CW'(DEPTH-1);
      end
    end else begin
      if (ARB_MODE != 0 && w_gnt_vld)
        r_rr_ptr <= (w_gnt_idx == VC_W'(NUM_VC-1)) ? '0 : w_gnt_idx + 1'b1;
      for (int d = 0; d < NUM_DEST; d++) begin
        if (init) r_thr[d] <= umbral[d*CW +: CW];
        if ((dest_pop[d] && r_count[d] == '0) || (w_push[d] && !w_wr_ok[d]))
          r_err[d] <= 1'b1;
        if (w_wr_ok[d]) r_wr_ptr[d] <= r_wr_ptr[d] + 1'b1;
        if (w_pop[d])   r_rd_ptr[d] <= r_rd_ptr[d] + 1'b1;
        r_count[d] <= r_count[d] + {{ADDR_WIDTH{1'b0}}, w_wr_ok[d]}
                                 - {{ADDR_WIDTH{1'b0}}, w_pop[d]};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DEST; d++)
      if (!reset && w_wr_ok[d]) r_mem[d][r_wr_ptr[d]] <= w_gnt_word;
  end

endmodule

// File: tb/tb_final_logic_param.sv
// Randomized scoreboard bench: instance A is the default strict-priority build, instance B is
// a 3-VC round-robin build with 3 destinations and 8-bit words (dest field index 3 folds to 2).
module tb_final_logic_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, init;

  logic [11:0] a_vc;  logic [1:0] a_emp, a_dpop, a_pop, a_e, a_af, a_err;
  logic [5:0]  a_umb; logic [11:0] a_dat;
  logic [23:0] b_vc;  logic [2:0] b_emp, b_dpop, b_pop, b_e, b_af, b_err;
  logic [8:0]  b_umb; logic [23:0] b_dat;

  final_logic_param dut_a (
    .clk(clk), .reset(reset), .init(init), .data_out_vc(a_vc), .empty_fifo_vc(a_emp),
    .dest_pop(a_dpop), .umbral(a_umb), .pop_vc(a_pop), .data_out_dest(a_dat),
    .empty_fifo_dest(a_e), .almost_full_dest(a_af), .error_dest(a_err));

  final_logic_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_VC(3), .NUM_DEST(3), .ARB_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .init(init), .data_out_vc(b_vc), .empty_fifo_vc(b_emp),
    .dest_pop(b_dpop), .umbral(b_umb), .pop_vc(b_pop), .data_out_dest(b_dat),
    .empty_fifo_dest(b_e), .almost_full_dest(b_af), .error_dest(b_err));

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0] vcq   [2][3][$];
  logic [7:0] destq [2][3][$];
  int cnt [2][3];
  int thr [2][3];
  bit err [2][3];
  int rr  [2];
  bit dp  [2][3];

  // Expectations for the cycle currently being presented
  bit e_valid = 1'b0;
  bit e_rst;
  int e_gnt [2];
  int e_cnt [2][3];
  bit e_af  [2][3];
  bit e_err [2][3];

  function automatic int nv(int u); return (u == 0) ? 2 : 3; endfunction
  function automatic int nd(int u); return (u == 0) ? 2 : 3; endfunction

  function automatic int dest_of(int u, logic [7:0] w);
    int f;
    if (u == 0) return int'(w[5]);
    f = int'(w[7:6]);
    return (f >= 3) ? 2 : f;
  endfunction

  function automatic bit af_m(int u, int d);
    int t;
    t = thr[u][d];
    if (t == 0 || t > 4) t = 4;
    return (cnt[u][d] >= t) || (cnt[u][d] == 4);
  endfunction

  function automatic int grant_m(int u);
    int v;
    if (reset || init) return -1;
    for (int k = 0; k < nv(u); k++) begin
      v = (u == 0) ? k : (rr[u] + k) % nv(u);
      if (vcq[u][v].size() > 0 && !af_m(u, dest_of(u, vcq[u][v][0]))) return v;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int g_pop(int u); return (u == 0) ? int'(a_pop) : int'(b_pop); endfunction
  function automatic bit g_e  (int u, int d); return (u == 0) ? a_e[d]   : b_e[d];   endfunction
  function automatic bit g_af (int u, int d); return (u == 0) ? a_af[d]  : b_af[d];  endfunction
  function automatic bit g_err(int u, int d); return (u == 0) ? a_err[d] : b_err[d]; endfunction
  function automatic int g_dat(int u, int d);
    return (u == 0) ? int'(a_dat[d*6 +: 6]) : int'(b_dat[d*8 +: 8]);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      rr[u] = 0;
      for (int d = 0; d < 3; d++) begin
        cnt[u][d] = 0; thr[u][d] = 3; err[u][d] = 1'b0;
        destq[u][d].delete();
      end
    end
  endtask

  // Monitor: compares whatever the DUTs present mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (e_valid) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d pop_vc", u), g_pop(u), (e_gnt[u] < 0) ? 0 : (1 << e_gnt[u]));
        for (int d = 0; d < nd(u); d++) begin
          chk($sformatf("u%0d d%0d empty", u, d), int'(g_e(u, d)), int'(e_cnt[u][d] == 0));
          chk($sformatf("u%0d d%0d almost_full", u, d), int'(g_af(u, d)), int'(e_af[u][d]));
          chk($sformatf("u%0d d%0d error", u, d), int'(g_err(u, d)), int'(e_err[u][d]));
          if (g_e(u, d)) begin
            chk($sformatf("u%0d d%0d data_empty", u, d), g_dat(u, d), 0);
          end else if (!e_rst) begin
            if (destq[u][d].size() == 0) begin
              chk($sformatf("u%0d d%0d scoreboard_underflow", u, d), g_dat(u, d), -1);
            end else begin
              chk($sformatf("u%0d d%0d data", u, d), g_dat(u, d), int'(destq[u][d][0]));
              if (dp[u][d]) void'(destq[u][d].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int pp, g, d;
    logic [7:0] w;
    reset = 1'b1; init = 1'b0;
    a_vc = '0; a_emp = '1; a_dpop = '0; a_umb = '0;
    b_vc = '0; b_emp = '1; b_dpop = '0; b_umb = '0;
    model_reset();
    for (int u = 0; u < 2; u++) for (int v = 0; v < 3; v++) vcq[u][v].delete();

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      reset = (cyc < 2) || (cyc == 1000) || ($urandom_range(0, 299) == 0);
      init  = !reset && (cyc >= 8) &&
              (($urandom_range(0, 24) == 0) || (cyc >= 700 && cyc < 703));
      a_umb = 6'($urandom);
      b_umb = 9'($urandom);
      if (cyc == 2) begin
        vcq[0][0].push_back(8'h05);
        vcq[0][1].push_back(8'h25);
      end
      pp = (cyc < 8) ? 0 : (cyc / 300 % 3 == 0) ? 50 : (cyc / 300 % 3 == 1) ? 15 : 85;
      for (int u = 0; u < 2; u++) begin
        for (int v = 0; v < nv(u); v++)
          if (cyc >= 8 && vcq[u][v].size() < 4 && $urandom_range(0, 2) != 0) begin
            w = 8'($urandom);
            if (u == 0) w[7:6] = 2'b00;
            vcq[u][v].push_back(w);
          end
        for (int dd = 0; dd < 3; dd++)
          dp[u][dd] = !reset && (dd < nd(u)) && ($urandom_range(0, 99) < pp);
      end
      for (int v = 0; v < 2; v++) begin
        a_emp[v] = (vcq[0][v].size() == 0);
        a_vc[v*6 +: 6] = a_emp[v] ? 6'd0 : vcq[0][v][0][5:0];
        a_dpop[v] = dp[0][v];
      end
      for (int v = 0; v < 3; v++) begin
        b_emp[v] = (vcq[1][v].size() == 0);
        b_vc[v*8 +: 8] = b_emp[v] ? 8'd0 : vcq[1][v][0];
        b_dpop[v] = dp[1][v];
      end

      e_rst = reset;
      for (int u = 0; u < 2; u++) begin
        e_gnt[u] = grant_m(u);
        for (int dd = 0; dd < 3; dd++) begin
          e_cnt[u][dd] = cnt[u][dd];
          e_af[u][dd]  = af_m(u, dd);
          e_err[u][dd] = err[u][dd];
        end
      end
      e_valid = 1'b1;

      // Advance the model across the coming edge.
      if (reset) begin
        model_reset();
      end else begin
        for (int u = 0; u < 2; u++) begin
          g = e_gnt[u];
          if (g >= 0) begin
            w = vcq[u][g].pop_front();
            d = dest_of(u, w);
            if (e_cnt[u][d] == 4) err[u][d] = 1'b1;
            else begin
              destq[u][d].push_back(w);
              cnt[u][d]++;
            end
            if (u == 1) rr[u] = (g + 1) % nv(u);
          end
          for (int dd = 0; dd < nd(u); dd++) begin
            if (dp[u][dd] && e_cnt[u][dd] == 0) err[u][dd] = 1'b1;
            if (dp[u][dd] && e_cnt[u][dd] > 0) cnt[u][dd]--;
            if (init) thr[u][dd] = (u == 0) ? int'(a_umb[dd*3 +: 3]) : int'(b_umb[dd*3 +: 3]);
          end
        end
      end
    end
    @(posedge clk); #1;
    e_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
